// File: rtl/h264dc_pkg.sv
// h264dc_pkg -- shared definitions for the H.264 luma DC coefficient collector.
//   COEFF_W_DEFAULT : default signed DC coefficient width
//   ROWS            : rows (and columns) of the 4x4 DC matrix
//   bank_state_e    : occupancy state of one 16-entry coefficient bank
//   collector_dbg_t : observable collector state (pointers and both bank states)
//   blk_to_raster() : maps H.264 4x4 block order k to raster index y*4+x
package h264dc_pkg;

    localparam int COEFF_W_DEFAULT = 16;
    localparam int ROWS            = 4;
    localparam int BANK_DEPTH      = ROWS * ROWS;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    typedef struct packed {
        logic        rd_ptr;
        logic        wr_ptr;
        bank_state_e bank1;
        bank_state_e bank0;
    } collector_dbg_t;

    // Block k sits at x = 2*k[2] + k[0], y = 2*k[3] + k[1].
    // Raster index y*4 + x is therefore just a bit shuffle of k.
    function automatic logic [3:0] blk_to_raster(input logic [3:0] k);
        return {k[3], k[1], k[2], k[0]};
    endfunction

endpackage

// File: rtl/h264dc_coeff_bank.sv
// h264dc_coeff_bank -- one 16-entry register bank holding a 4x4 DC matrix in
// raster order, with one write port and one whole-row read port.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents)
//   wr_en      : write wr_data at raster index wr_addr this cycle
//   wr_addr    : raster index y*4+x
//   wr_data    : coefficient to store (bit-exact, no arithmetic)
//   rd_row     : row to present on rd_data
//   rd_data    : the four coefficients of rd_row, column 0 in the LSBs
module h264dc_coeff_bank
    import h264dc_pkg::*;
#(
    parameter int COEFF_W = COEFF_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [COEFF_W-1:0]     wr_data,
    input  logic [1:0]             rd_row,
    output logic [4*COEFF_W-1:0]   rd_data
);

    logic [COEFF_W-1:0] mem_q [BANK_DEPTH];
    logic [COEFF_W-1:0] mem_d [BANK_DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = {mem_q[{rd_row, 2'd3}], mem_q[{rd_row, 2'd2}],
                   mem_q[{rd_row, 2'd1}], mem_q[{rd_row, 2'd0}]};
    end

endmodule

// File: rtl/h264dc_coeff_collector.sv
// h264dc_coeff_collector -- gathers the 16 luma DC coefficients of a macroblock
// (arriving in H.264 4x4 block order) into a double-buffered 4x4 matrix and
// hands it downstream one raster row at a time.
//   CLK, RESET : clock, asynchronous active-low reset
//   DC_IN      : signed DC coefficient, DC_VALID / DC_READY handshake
//   ROW_OUT    : one raster row (column 0 in LSBs), ROW_VALID / ROW_READY
//   ROW_IDX    : row number of ROW_OUT, ROW_LAST high with row 3
//   DBG_STATE  : read/write pointers and both bank states
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high. A producer holding valid keeps its data stable until the transfer;
// ready may change freely and never depends on the same side's valid.
module h264dc_coeff_collector
    import h264dc_pkg::*;
#(
    parameter int COEFF_W = COEFF_W_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [COEFF_W-1:0]     DC_IN,
    input  logic                   DC_VALID,
    output logic                   DC_READY,
    output logic [4*COEFF_W-1:0]   ROW_OUT,
    output logic                   ROW_VALID,
    input  logic                   ROW_READY,
    output logic [1:0]             ROW_IDX,
    output logic                   ROW_LAST,
    output collector_dbg_t         DBG_STATE
);

    bank_state_e bank_state_q [2];
    bank_state_e bank_state_d [2];
    logic        wr_ptr_q,  wr_ptr_d;
    logic        rd_ptr_q,  rd_ptr_d;
    logic [3:0]  in_cnt_q,  in_cnt_d;
    logic [1:0]  row_idx_q, row_idx_d;

    logic                 in_fire;
    logic                 out_fire;
    logic [1:0]           bank_wr_en;
    logic [4*COEFF_W-1:0] bank_rd_data [2];

    // Ready/valid come straight from the registered bank states.
    always_comb begin
        DC_READY  = (bank_state_q[wr_ptr_q] != BANK_FULL);
        ROW_VALID = (bank_state_q[rd_ptr_q] == BANK_FULL);
        in_fire   = DC_VALID  && DC_READY;
        out_fire  = ROW_VALID && ROW_READY;
    end

    // An input needs a non-FULL bank and an output needs a FULL one, so the two
    // fires can never touch the same bank: both updates apply independently.
    always_comb begin
        bank_state_d = bank_state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        in_cnt_d     = in_cnt_q;
        row_idx_d    = row_idx_q;
        if (in_fire) begin
            in_cnt_d = in_cnt_q + 4'd1;
            if (in_cnt_q == 4'd15) begin
                bank_state_d[wr_ptr_q] = BANK_FULL;
                wr_ptr_d               = ~wr_ptr_q;
            end else begin
                bank_state_d[wr_ptr_q] = BANK_FILLING;
            end
        end
        if (out_fire) begin
            row_idx_d = row_idx_q + 2'd1;
            if (row_idx_q == 2'd3) begin
                bank_state_d[rd_ptr_q] = BANK_EMPTY;
                rd_ptr_d               = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bank_state_q[0] <= BANK_EMPTY;
            bank_state_q[1] <= BANK_EMPTY;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            in_cnt_q        <= 4'd0;
            row_idx_q       <= 2'd0;
        end else begin
            bank_state_q <= bank_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            in_cnt_q     <= in_cnt_d;
            row_idx_q    <= row_idx_d;
        end
    end

    always_comb begin
        bank_wr_en[0] = in_fire && !wr_ptr_q;
        bank_wr_en[1] = in_fire &&  wr_ptr_q;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        h264dc_coeff_bank #(
            .COEFF_W (COEFF_W)
        ) u_bank (
            .clk     (CLK),
            .rst_n   (RESET),
            .wr_en   (bank_wr_en[b]),
            .wr_addr (blk_to_raster(in_cnt_q)),
            .wr_data (DC_IN),
            .rd_row  (row_idx_q),
            .rd_data (bank_rd_data[b])
        );
    end

    // Row data is forced to zero whenever no row is offered, so reset and idle
    // both present ROW_OUT = 0.
    always_comb begin
        ROW_OUT   = ROW_VALID ? bank_rd_data[rd_ptr_q] : '0;
        ROW_IDX   = row_idx_q;
        ROW_LAST  = ROW_VALID && (row_idx_q == 2'd3);
        DBG_STATE = '{rd_ptr: rd_ptr_q, wr_ptr: wr_ptr_q,
                      bank1: bank_state_q[1], bank0: bank_state_q[0]};
    end

endmodule

// File: tb/tb_h264dc_coeff_collector.sv
module tb_h264dc_coeff_collector;
    import h264dc_pkg::*;

    localparam int W  = 16;
    localparam int RW = 4 * W;

    logic           CLK = 1'b0;
    logic           RESET = 1'b0;
    logic [W-1:0]   DC_IN = '0;
    logic           DC_VALID = 1'b0;
    logic           DC_READY;
    logic [RW-1:0]  ROW_OUT;
    logic           ROW_VALID;
    logic           ROW_READY = 1'b0;
    logic [1:0]     ROW_IDX;
    logic           ROW_LAST;
    collector_dbg_t DBG_STATE;

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0] exp_q[$];
    logic [W-1:0]  mb_vals [16];
    logic [W-1:0]  stream  [48];

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    h264dc_coeff_collector #(.COEFF_W(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DC_IN     (DC_IN),
        .DC_VALID  (DC_VALID),
        .DC_READY  (DC_READY),
        .ROW_OUT   (ROW_OUT),
        .ROW_VALID (ROW_VALID),
        .ROW_READY (ROW_READY),
        .ROW_IDX   (ROW_IDX),
        .ROW_LAST  (ROW_LAST),
        .DBG_STATE (DBG_STATE)
    );

    task automatic apply_reset();
        RESET     = 1'b0;
        DC_VALID  = 1'b0;
        ROW_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    // ---------------- model: block order -> raster rows ----------------
    task automatic push_mb_rows();
        logic [W-1:0] grid [4][4];
        for (int k = 0; k < 16; k++) begin
            int x, y;
            x = 2 * ((k >> 2) & 1) + (k & 1);
            y = 2 * ((k >> 3) & 1) + ((k >> 1) & 1);
            grid[y][x] = mb_vals[k];
        end
        for (int y = 0; y < 4; y++) begin
            exp_q.push_back({grid[y][3], grid[y][2], grid[y][1], grid[y][0]});
        end
    endtask

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic drive_dc(input logic [W-1:0] v);
        bit rdy;
        int n;
        n = 0;
        DC_IN    = v;
        DC_VALID = 1'b1;
        do begin
            @(negedge CLK);
            rdy = DC_READY;
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 500);
        DC_VALID = 1'b0;
        checks++;
        if (!rdy) begin
            failures++;
            $display("FAIL dc_accept_timeout value=%h not accepted within %0d cycles", v, n);
        end
    endtask

    // mode 0: ROW_READY always high; mode 1: ROW_READY toggles 1,0,1,0...
    task automatic drain_rows(input int n, input int mode);
        int got, cyc;
        bit rdy, held_v;
        logic [RW-1:0] held_row;
        logic [1:0] held_idx, ei;
        logic [RW-1:0] er;
        got = 0; cyc = 0; held_v = 0; held_row = '0; held_idx = '0;
        while (got < n && cyc < 3000) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            ROW_READY = rdy;
            @(negedge CLK);
            if (held_v) begin
                checks++;
                if (ROW_VALID !== 1'b1 || ROW_OUT !== held_row || ROW_IDX !== held_idx) begin
                    failures++;
                    $display("FAIL row_stall_stable valid=%b row=%h idx=%0d required valid=1 row=%h idx=%0d",
                             ROW_VALID, ROW_OUT, ROW_IDX, held_row, held_idx);
                end
            end
            if (ROW_VALID === 1'b1) begin
                ei = 2'(got & 3);
                if (rdy) begin
                    er = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    checks++;
                    if (ROW_OUT !== er || ROW_IDX !== ei || ROW_LAST !== (ei == 2'd3)) begin
                        failures++;
                        $display("FAIL row_data row#%0d got row=%h idx=%0d last=%b required row=%h idx=%0d last=%b",
                                 got, ROW_OUT, ROW_IDX, ROW_LAST, er, ei, (ei == 2'd3));
                    end
                    got++;
                    held_v = 0;
                end else begin
                    held_v   = 1;
                    held_row = ROW_OUT;
                    held_idx = ROW_IDX;
                end
            end else begin
                held_v = 0;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        ROW_READY = 1'b0;
        checks++;
        if (got < n) begin
            failures++;
            $display("FAIL row_drain_timeout got=%0d rows required=%0d", got, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (ROW_VALID !== 1'b0 || ROW_LAST !== 1'b0 || DC_READY !== 1'b1 || ROW_OUT !== '0 || DBG_STATE !== '0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b last=%b ready=%b row=%h dbg=%h required 0 0 1 0 0",
                     ROW_VALID, ROW_LAST, DC_READY, ROW_OUT, DBG_STATE);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (ROW_VALID !== 1'b0 || DC_READY !== 1'b1 || ROW_IDX !== 2'd0 || ROW_OUT !== '0) begin
            failures++;
            $display("FAIL after_reset valid=%b ready=%b idx=%0d row=%h required 0 1 0 0",
                     ROW_VALID, DC_READY, ROW_IDX, ROW_OUT);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_raster_order();
        logic [RW-1:0] rows [4];
        collector_dbg_t ed;
        rows[0] = {16'd5,  16'd4,  16'd1,  16'd0};
        rows[1] = {16'd7,  16'd6,  16'd3,  16'd2};
        rows[2] = {16'd13, 16'd12, 16'd9,  16'd8};
        rows[3] = {16'd15, 16'd14, 16'd11, 16'd10};
        apply_reset();
        ROW_READY = 1'b1;
        for (int k = 0; k < 16; k++) begin
            DC_IN    = W'(k);
            DC_VALID = 1'b1;
            @(negedge CLK);
            checks++;
            if (DC_READY !== 1'b1 || ROW_VALID !== 1'b0) begin
                failures++;
                $display("FAIL raster_fill k=%0d ready=%b valid=%b required ready=1 valid=0", k, DC_READY, ROW_VALID);
            end
            @(posedge CLK); #1;
        end
        DC_VALID = 1'b0;
        for (int r = 0; r < 4; r++) begin
            @(negedge CLK);
            checks++;
            if (ROW_VALID !== 1'b1 || ROW_OUT !== rows[r] || ROW_IDX !== 2'(r) || ROW_LAST !== (r == 3)) begin
                failures++;
                $display("FAIL raster_row r=%0d valid=%b row=%h idx=%0d last=%b required 1 %h %0d %b",
                         r, ROW_VALID, ROW_OUT, ROW_IDX, ROW_LAST, rows[r], r, (r == 3));
            end
            @(posedge CLK); #1;
        end
        ROW_READY = 1'b0;
        ed = '{rd_ptr: 1'b1, wr_ptr: 1'b1, bank1: BANK_EMPTY, bank0: BANK_EMPTY};
        @(negedge CLK);
        checks++;
        if (ROW_VALID !== 1'b0 || DBG_STATE !== ed) begin
            failures++;
            $display("FAIL raster_done valid=%b dbg=%h required valid=0 dbg=%h", ROW_VALID, DBG_STATE, ed);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure();
        collector_dbg_t ed;
        apply_reset();
        for (int i = 0; i < 48; i++) stream[i] = W'(16'h0100 + i * 3);
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 16; k++) mb_vals[k] = stream[16 * m + k];
            push_mb_rows();
        end
        ROW_READY = 1'b0;
        for (int i = 0; i < 32; i++) drive_dc(stream[i]);
        ed = '{rd_ptr: 1'b0, wr_ptr: 1'b0, bank1: BANK_FULL, bank0: BANK_FULL};
        DC_IN    = stream[32];
        DC_VALID = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (DC_READY !== 1'b0 || ROW_VALID !== 1'b1 || ROW_OUT !== exp_q[0] || ROW_IDX !== 2'd0 || DBG_STATE !== ed) begin
                failures++;
                $display("FAIL bp_full_hold c=%0d ready=%b valid=%b row=%h idx=%0d dbg=%h required 0 1 %h 0 %h",
                         c, DC_READY, ROW_VALID, ROW_OUT, ROW_IDX, DBG_STATE, exp_q[0], ed);
            end
            @(posedge CLK); #1;
        end
        ROW_READY = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge CLK);
            checks++;
            if (DC_READY !== 1'b0 || ROW_VALID !== 1'b1 || ROW_OUT !== exp_q[0] || ROW_IDX !== 2'(r) || ROW_LAST !== (r == 3)) begin
                failures++;
                $display("FAIL bp_drain r=%0d ready=%b valid=%b row=%h idx=%0d last=%b required 0 1 %h %0d %b",
                         r, DC_READY, ROW_VALID, ROW_OUT, ROW_IDX, ROW_LAST, exp_q[0], r, (r == 3));
            end
            @(posedge CLK); #1;
            void'(exp_q.pop_front());
        end
        ROW_READY = 1'b0;
        @(negedge CLK);
        checks++;
        if (DC_READY !== 1'b1 || ROW_VALID !== 1'b1 || ROW_IDX !== 2'd0) begin
            failures++;
            $display("FAIL bp_ready_return ready=%b valid=%b idx=%0d required 1 1 0", DC_READY, ROW_VALID, ROW_IDX);
        end
        @(posedge CLK); #1;
        DC_VALID = 1'b0;
        fork
            begin
                for (int i = 33; i < 48; i++) drive_dc(stream[i]);
            end
            drain_rows(8, 0);
        join
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 48; i++) stream[i] = W'($urandom_range(0, 65535));
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 16; k++) mb_vals[k] = stream[16 * m + k];
            push_mb_rows();
        end
        fork
            begin
                for (int i = 0; i < 48; i++) drive_dc(stream[i]);
            end
            drain_rows(12, 1);
        join
    endtask

    task automatic test_collision();
        collector_dbg_t ed;
        apply_reset();
        for (int k = 0; k < 16; k++) stream[k]      = W'(16'h1000 + k);
        for (int k = 0; k < 16; k++) stream[16 + k] = W'(16'h2000 + 7 * k);
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) mb_vals[k] = stream[16 * m + k];
            push_mb_rows();
        end
        ROW_READY = 1'b0;
        for (int i = 0; i < 31; i++) drive_dc(stream[i]);
        ROW_READY = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge CLK);
            checks++;
            if (ROW_VALID !== 1'b1 || ROW_OUT !== exp_q[0] || ROW_IDX !== 2'(r)) begin
                failures++;
                $display("FAIL coll_row r=%0d valid=%b row=%h idx=%0d required 1 %h %0d",
                         r, ROW_VALID, ROW_OUT, ROW_IDX, exp_q[0], r);
            end
            @(posedge CLK); #1;
            void'(exp_q.pop_front());
        end
        DC_IN    = stream[31];
        DC_VALID = 1'b1;
        @(negedge CLK);
        checks++;
        if (DC_READY !== 1'b1 || ROW_VALID !== 1'b1 || ROW_IDX !== 2'd3 || ROW_LAST !== 1'b1 || ROW_OUT !== exp_q[0]) begin
            failures++;
            $display("FAIL coll_same_cycle ready=%b valid=%b idx=%0d last=%b row=%h required 1 1 3 1 %h",
                     DC_READY, ROW_VALID, ROW_IDX, ROW_LAST, ROW_OUT, exp_q[0]);
        end
        @(posedge CLK); #1;
        void'(exp_q.pop_front());
        DC_VALID  = 1'b0;
        ROW_READY = 1'b0;
        ed = '{rd_ptr: 1'b1, wr_ptr: 1'b0, bank1: BANK_FULL, bank0: BANK_EMPTY};
        @(negedge CLK);
        checks++;
        if (ROW_VALID !== 1'b1 || ROW_IDX !== 2'd0 || ROW_OUT !== exp_q[0] || DC_READY !== 1'b1 || DBG_STATE !== ed) begin
            failures++;
            $display("FAIL coll_next valid=%b idx=%0d row=%h ready=%b dbg=%h required 1 0 %h 1 %h",
                     ROW_VALID, ROW_IDX, ROW_OUT, DC_READY, DBG_STATE, exp_q[0], ed);
        end
        @(posedge CLK); #1;
        drain_rows(4, 0);
    endtask

    task automatic test_mid_reset();
        collector_dbg_t ed;
        apply_reset();
        ROW_READY = 1'b0;
        for (int i = 0; i < 7; i++) drive_dc(W'(16'h0aa0 + i));
        ed = '{rd_ptr: 1'b0, wr_ptr: 1'b0, bank1: BANK_EMPTY, bank0: BANK_FILLING};
        @(negedge CLK);
        checks++;
        if (DBG_STATE !== ed) begin
            failures++;
            $display("FAIL partial_fill dbg=%h required %h", DBG_STATE, ed);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (ROW_VALID !== 1'b0 || DC_READY !== 1'b1 || ROW_OUT !== '0 || ROW_LAST !== 1'b0 || DBG_STATE !== '0) begin
            failures++;
            $display("FAIL mid_reset valid=%b ready=%b row=%h last=%b dbg=%h required 0 1 0 0 0",
                     ROW_VALID, DC_READY, ROW_OUT, ROW_LAST, DBG_STATE);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
        for (int k = 0; k < 16; k++) mb_vals[k] = W'(16'h8000 + k);
        push_mb_rows();
        fork
            begin
                for (int k = 0; k < 16; k++) drive_dc(mb_vals[k]);
            end
            drain_rows(4, 0);
        join
    endtask

    task automatic test_gaps();
        apply_reset();
        exp_q.push_back({16'd5,  16'd4,  16'd1,  16'd0});
        exp_q.push_back({16'd7,  16'd6,  16'd3,  16'd2});
        exp_q.push_back({16'd13, 16'd12, 16'd9,  16'd8});
        exp_q.push_back({16'd15, 16'd14, 16'd11, 16'd10});
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    int gap;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge CLK); #1;
                    end
                    drive_dc(W'(k));
                end
            end
            drain_rows(4, 0);
        join
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_raster_order();
        test_backpressure();
        test_back_to_back();
        test_collision();
        test_mid_reset();
        test_gaps();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_rows got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
